// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths, opcodes, memory-unit FSM states and opcode classifiers.
package fcpu_pkg;
  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 4;
  localparam int INSTR_W  = 6;
  localparam int CDB_W    = RSV_ID_W + DATA_W;
  localparam logic [INSTR_W-1:0] I_NOP     = 6'd0;
  localparam logic [INSTR_W-1:0] I_ADD     = 6'd1;
  localparam logic [INSTR_W-1:0] I_SUB     = 6'd2;
  localparam logic [INSTR_W-1:0] I_LOAD    = 6'd16;
  localparam logic [INSTR_W-1:0] I_LOADB   = 6'd17;
  localparam logic [INSTR_W-1:0] I_LOADR   = 6'd18;
  localparam logic [INSTR_W-1:0] I_LOADF   = 6'd19;
  localparam logic [INSTR_W-1:0] I_LOADBF  = 6'd20;
  localparam logic [INSTR_W-1:0] I_LOADRF  = 6'd21;
  localparam logic [INSTR_W-1:0] I_STORE   = 6'd24;
  localparam logic [INSTR_W-1:0] I_STOREB  = 6'd25;
  localparam logic [INSTR_W-1:0] I_STORER  = 6'd26;
  localparam logic [INSTR_W-1:0] I_STOREF  = 6'd27;
  localparam logic [INSTR_W-1:0] I_STOREBF = 6'd28;
  localparam logic [INSTR_W-1:0] I_STORERF = 6'd29;
  localparam logic [INSTR_W-1:0] I_INPUT   = 6'd32;
  localparam logic [INSTR_W-1:0] I_INPUTF  = 6'd33;
  localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'd34;
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_RD_WAIT, S_IN_WAIT, S_OUT_WAIT, S_RESP
  } dmu_state_t;
  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [INSTR_W-1:0]  opcode;
  } dmu_req_t;
  function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
    return op inside {I_LOAD, I_LOADB, I_LOADR, I_LOADF, I_LOADBF, I_LOADRF};
  endfunction
  function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
    return op inside {I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF};
  endfunction
  function automatic logic is_io_op(input logic [INSTR_W-1:0] op);
    return op inside {I_INPUT, I_INPUTF, I_OUTPUT};
  endfunction
endpackage

// File: rtl/data_memory_unit.sv
// data_memory_unit: executes one load/store/input/output request at a time against
// an external synchronous RAM or byte streams, returning results on a CDB port.
module data_memory_unit
  import fcpu_pkg::*;
#(
  parameter int DRAM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RSV_ID_W-1:0]    i_rsv_id,
  input  logic                   i_valid,
  input  logic [DATA_W-1:0]      i_data,
  input  logic [DATA_W-1:0]      i_addr,
  input  logic [INSTR_W-1:0]     i_opcode,
  output logic                   i_ready,
  output logic [CDB_W-1:0]       o_cdb,
  output logic                   o_cdb_valid,
  input  logic                   o_cdb_ready,
  output logic [DRAM_ADDR_W-1:0] dram_addr,
  output logic                   dram_we,
  output logic [DATA_W-1:0]      dram_wdata,
  input  logic [DATA_W-1:0]      dram_rdata,
  input  logic [7:0]             io_in_data,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  output logic [7:0]             io_out_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready
);
  dmu_state_t state;
  dmu_req_t   req;
  logic       in_op;
  logic       unused_addr;
  assign unused_addr  = ^i_addr[DATA_W-1:DRAM_ADDR_W];
  assign in_op        = is_io_op(req.opcode) && req.opcode != I_OUTPUT;
  // Handshake strobes are gated by rst so nothing is accepted or emitted in a reset cycle.
  assign i_ready      = state == S_IDLE && !rst;
  assign io_in_ready  = state == S_IN_WAIT && !rst;
  assign io_out_valid = state == S_OUT_WAIT && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req         <= '0;
      o_cdb       <= '0;
      o_cdb_valid <= 1'b0;
      dram_we     <= 1'b0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
      io_out_data <= '0;
    end else begin
      dram_we <= 1'b0;
      case (state)
        S_IDLE: if (i_valid) begin
          req        <= '{rsv_id: i_rsv_id, opcode: i_opcode};
          dram_addr  <= i_addr[DRAM_ADDR_W-1:0];
          dram_wdata <= i_data;
          dram_we    <= is_store_op(i_opcode);
          if (i_opcode == I_OUTPUT) io_out_data <= i_data[7:0];
          state <= S_EXEC;
        end
        S_EXEC: state <= is_load_op(req.opcode) ? S_RD_WAIT :
                         in_op                  ? S_IN_WAIT :
                         req.opcode == I_OUTPUT ? S_OUT_WAIT : S_IDLE;
        S_RD_WAIT: begin
          o_cdb       <= {req.rsv_id, dram_rdata};
          o_cdb_valid <= 1'b1;
          state       <= S_RESP;
        end
        S_IN_WAIT: if (io_in_valid) begin
          o_cdb       <= {req.rsv_id, 24'b0, io_in_data};
          o_cdb_valid <= 1'b1;
          state       <= S_RESP;
        end
        S_OUT_WAIT: if (io_out_ready) state <= S_IDLE;
        S_RESP: if (o_cdb_ready) begin
          o_cdb_valid <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed stimulus with a CDB/output-byte scoreboard and a RAM model.
module tb_data_memory_unit;
  import fcpu_pkg::*;
  logic clk = 0, rst = 1;
  logic [RSV_ID_W-1:0] i_rsv_id = '0;
  logic i_valid = 0;
  logic [DATA_W-1:0] i_data = '0, i_addr = '0;
  logic [INSTR_W-1:0] i_opcode = '0;
  logic i_ready;
  logic [CDB_W-1:0] o_cdb;
  logic o_cdb_valid, o_cdb_ready = 1;
  logic [15:0] dram_addr;
  logic dram_we;
  logic [DATA_W-1:0] dram_wdata, dram_rdata;
  logic [7:0] io_in_data = '0, io_out_data;
  logic io_in_valid = 0, io_in_ready, io_out_valid, io_out_ready = 0;
  logic pre_we = 0;
  logic [7:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  logic [DATA_W-1:0] mem [256];
  logic [CDB_W-1:0] exp_q [$];
  logic [7:0] out_q [$];
  int tests = 0, fails = 0, cdb_count = 0, out_count = 0, we_count = 0;

  data_memory_unit dut (
    .clk(clk), .rst(rst), .i_rsv_id(i_rsv_id), .i_valid(i_valid), .i_data(i_data),
    .i_addr(i_addr), .i_opcode(i_opcode), .i_ready(i_ready), .o_cdb(o_cdb),
    .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready), .dram_addr(dram_addr),
    .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_out_data(io_out_data), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dram_we) mem[dram_addr[7:0]] <= dram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    dram_rdata <= mem[dram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    logic [CDB_W-1:0] e;
    logic [7:0] b;
    if (dram_we) we_count++;
    if (o_cdb_valid && o_cdb_ready) begin
      cdb_count++;
      e = exp_q.size() != 0 ? exp_q.pop_front() : {CDB_W{1'bx}};
      chk("cdb_result", o_cdb, e);
    end
    if (io_out_valid && io_out_ready) begin
      out_count++;
      b = out_q.size() != 0 ? out_q.pop_front() : 8'hxx;
      chk("io_out_byte", io_out_data, b);
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  // Returns one time unit after the accepting edge, i.e. in the EXEC cycle.
  task automatic issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] id,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] a);
    logic hs = 0;
    i_valid = 1; i_opcode = op; i_rsv_id = id; i_data = d; i_addr = a;
    for (int k = 0; k < 50 && !hs; k++) begin
      #3 hs = i_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    chk("accept", hs, 1);
  endtask

  task automatic wait_idle();
    logic r = 0;
    for (int k = 0; k < 50 && !r; k++) begin
      #3 r = i_ready;
      if (!r) begin
        @(posedge clk);
        #1;
      end
    end
    chk("idle_timeout", r, 1);
    nxt();
  endtask

  initial begin
    int w0, c0, o0;
    #1 pre_we = 1; pre_addr = 8'h10; pre_data = 32'hDEADBEEF;
    nxt(2);
    pre_we = 0;
    smp();
    chk("rst_i_ready", i_ready, 0);
    chk("rst_cdb", o_cdb, 0);
    chk("rst_cdb_valid", o_cdb_valid, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_addr", dram_addr, 0);
    chk("rst_wdata", dram_wdata, 0);
    chk("rst_in_ready", io_in_ready, 0);
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_out_data", io_out_data, 0);
    nxt();
    rst = 0;
    smp();
    chk("post_rst_i_ready", i_ready, 1);
    nxt();

    c0 = cdb_count;
    exp_q.push_back({4'd5, 32'hDEADBEEF});
    issue(I_LOAD, 4'd5, 32'h0, 32'h0001_0010);
    smp();
    chk("ld_exec_addr", dram_addr, 16'h0010);
    chk("ld_exec_we", dram_we, 0);
    nxt(); smp();
    chk("ld_t2_valid", o_cdb_valid, 0);
    nxt(); smp();
    chk("ld_t3_valid", o_cdb_valid, 1);
    chk("ld_t3_cdb", o_cdb, {4'd5, 32'hDEADBEEF});
    nxt(); smp();
    chk("ld_t4_ready", i_ready, 1);
    chk("ld_t4_valid", o_cdb_valid, 0);
    chk("ld_single", cdb_count - c0, 1);
    nxt();

    w0 = we_count;
    issue(I_STORE, 4'd1, 32'h12345678, 32'h20);
    smp();
    chk("st_t1_we", dram_we, 1);
    chk("st_t1_wdata", dram_wdata, 32'h12345678);
    chk("st_t1_addr", dram_addr, 16'h0020);
    chk("st_t1_ready", i_ready, 0);
    nxt(); smp();
    chk("st_t2_we", dram_we, 0);
    chk("st_t2_ready", i_ready, 1);
    chk("st_we_pulses", we_count - w0, 1);
    nxt();
    exp_q.push_back({4'd2, 32'h12345678});
    issue(I_LOADF, 4'd2, 32'h0, 32'h20);
    wait_idle();

    o_cdb_ready = 0;
    c0 = cdb_count;
    exp_q.push_back({4'd7, 32'hDEADBEEF});
    issue(I_LOADB, 4'd7, 32'h0, 32'h10);
    nxt(2); smp();
    chk("bp_valid", o_cdb_valid, 1);
    for (int k = 0; k < 5; k++) begin
      nxt(); smp();
      chk("bp_cdb_stable", o_cdb, {4'd7, 32'hDEADBEEF});
      chk("bp_i_ready", i_ready, 0);
    end
    nxt();
    o_cdb_ready = 1;
    nxt(); smp();
    chk("bp_one_xfer", cdb_count - c0, 1);
    chk("bp_ready_back", i_ready, 1);
    nxt();

    c0 = cdb_count;
    exp_q.push_back({4'd3, 32'h00000041});
    issue(I_INPUT, 4'd3, 32'h0, 32'h0);
    smp();
    chk("in_exec_ready", io_in_ready, 0);
    nxt(); smp();
    chk("in_wait_ready", io_in_ready, 1);
    nxt(3);
    io_in_valid = 1; io_in_data = 8'h41;
    nxt();
    io_in_valid = 0; io_in_data = 8'h00;
    smp();
    chk("in_done_ready", io_in_ready, 0);
    wait_idle();
    chk("in_one_xfer", cdb_count - c0, 1);

    c0 = cdb_count; o0 = out_count;
    out_q.push_back(8'h42);
    issue(I_OUTPUT, 4'd1, 32'h1234_5642, 32'h0);
    smp();
    chk("out_exec_valid", io_out_valid, 0);
    nxt(); smp();
    chk("out_wait_valid", io_out_valid, 1);
    chk("out_data", io_out_data, 8'h42);
    nxt(3);
    io_out_ready = 1;
    nxt();
    io_out_ready = 0;
    smp();
    chk("out_done_valid", io_out_valid, 0);
    chk("out_ready_back", i_ready, 1);
    chk("out_one_byte", out_count - o0, 1);
    chk("out_no_cdb", cdb_count - c0, 0);
    nxt();

    o_cdb_ready = 0;
    c0 = cdb_count;
    issue(I_LOAD, 4'd9, 32'h0, 32'h10);
    nxt(2); smp();
    chk("rr_valid_before", o_cdb_valid, 1);
    nxt();
    rst = 1;
    nxt(); smp();
    chk("rr_cdb_valid", o_cdb_valid, 0);
    chk("rr_cdb", o_cdb, 0);
    chk("rr_addr", dram_addr, 0);
    chk("rr_i_ready", i_ready, 0);
    nxt();
    rst = 0; o_cdb_ready = 1;
    nxt(5);
    chk("rr_no_cdb", cdb_count - c0, 0);

    o0 = out_count;
    issue(I_OUTPUT, 4'd1, 32'h0000_00AB, 32'h0);
    nxt(); smp();
    chk("ro_valid_before", io_out_valid, 1);
    nxt();
    rst = 1; io_out_ready = 1;
    nxt(); smp();
    chk("ro_out_valid", io_out_valid, 0);
    chk("ro_out_data", io_out_data, 0);
    chk("ro_we", dram_we, 0);
    nxt();
    rst = 0;
    nxt(4);
    io_out_ready = 0;
    chk("ro_no_byte", out_count - o0, 0);
    out_q.delete();

    w0 = we_count; c0 = cdb_count; o0 = out_count;
    issue(I_ADD, 4'd4, 32'hFFFF_FFFF, 32'h30);
    smp();
    chk("add_t1_ready", i_ready, 0);
    chk("add_t1_we", dram_we, 0);
    nxt(); smp();
    chk("add_t2_ready", i_ready, 1);
    nxt(3);
    chk("add_no_we", we_count - w0, 0);
    chk("add_no_cdb", cdb_count - c0, 0);
    chk("add_no_io", out_count - o0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
